// File: rtl/decoder_scan_n_to_2n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n_to_2n
//
// Registered N-to-2^N binary decoder with two operating modes:
//   direct : registered decode of a qualified address (a_i / a_valid_i).
//   scan   : self-timed walking one-hot, each index held for dwell_i+1 cycles,
//            indices 0..last_i visited before wrapping back to 0.
//
// Parameters
//   ADDR_W  : address width N; out_o is 2^ADDR_W bits wide.
//   DWELL_W : width of the dwell counter and of dwell_i.
//
// Ports
//   clk_i      in   1        system clock, all state on rising edge
//   rst_i      in   1        asynchronous, active-high reset
//   en_i       in   1        block enable; low forces outputs inactive
//   mode_i     in   1        0 = direct, 1 = scan
//   a_i        in   ADDR_W   direct-mode address
//   a_valid_i  in   1        qualifies a_i (direct mode only)
//   dwell_i    in   DWELL_W  scan: extra cycles each output is held
//   last_i     in   ADDR_W   scan: highest index visited before wrap
//   out_o      out  2^ADDR_W one-hot decoded output (registered)
//   idx_o      out  ADDR_W   index of the currently asserted bit (registered)
//   wrap_o     out  1        one-cycle pulse when scan returns to index 0
//
// Build option
//   DECODER_SCAN_ACTIVE_LOW_EN : when defined, out_o is the bitwise inverse of
//   the one-hot value (inactive/reset value all ones, active bit 0). idx_o,
//   wrap_o and all timing are unaffected.
// -----------------------------------------------------------------------------
module decoder_scan_n_to_2n #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic [ADDR_W-1:0]        a_i,
  input  logic                     a_valid_i,
  input  logic [DWELL_W-1:0]       dwell_i,
  input  logic [ADDR_W-1:0]        last_i,
  output logic [(1<<ADDR_W)-1:0]   out_o,
  output logic [ADDR_W-1:0]        idx_o,
  output logic                     wrap_o
);

  localparam int OUT_W = 1 << ADDR_W;

  localparam logic [OUT_W-1:0]   OUT_ZERO   = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]   OUT_ONE    = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  // XOR mask applied to every value written to out_q.
  localparam logic [OUT_W-1:0] OUT_POL = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] OUT_POL = {OUT_W{1'b0}};
`endif

  // Inactive level of out_o (all zeros active-high, all ones active-low).
  localparam logic [OUT_W-1:0] OUT_INACTIVE = OUT_ZERO ^ OUT_POL;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // One-hot decode of an index, already converted to output polarity.
  function automatic logic [OUT_W-1:0] decode_out(input logic [ADDR_W-1:0] sel);
    decode_out = (OUT_ONE << sel) ^ OUT_POL;
  endfunction

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  // Scan advance target: wrap to 0 once idx reaches or passes last. Using >=
  // means lowering last below the current index wraps on the next advance.
  logic [ADDR_W-1:0]  scan_next_idx_s;
  logic               scan_wraps_s;

  // Next scan index and whether that advance is a wrap.
  always_comb begin
    scan_wraps_s    = 1'b0;
    scan_next_idx_s = idx_q + ADDR_ONE;
    if (idx_q >= last_i) begin
      scan_wraps_s    = 1'b1;
      scan_next_idx_s = ADDR_ZERO;
    end else begin
      scan_wraps_s    = 1'b0;
      scan_next_idx_s = idx_q + ADDR_ONE;
    end
  end

  // Next-state and next-output logic; priority is en > mode > a_valid.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;

    if (!en_i) begin
      // Disabled: outputs inactive, idx keeps its last value.
      state_d     = ST_IDLE;
      out_d       = OUT_INACTIVE;
      dwell_cnt_d = DWELL_ZERO;
    end else if (mode_i) begin
      case (state_q)
        ST_SCAN: begin
          state_d = ST_SCAN;
          if (dwell_cnt_q == dwell_i) begin
            dwell_cnt_d = DWELL_ZERO;
            idx_d       = scan_next_idx_s;
            out_d       = decode_out(scan_next_idx_s);
            wrap_d      = scan_wraps_s;
          end else begin
            // A dwell lowered below the running count free-runs to rollover.
            dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
          end
        end
        ST_IDLE, ST_DIRECT: begin
          // Scan entry always restarts at bit 0; a_valid is ignored here.
          state_d     = ST_SCAN;
          idx_d       = ADDR_ZERO;
          out_d       = decode_out(ADDR_ZERO);
          dwell_cnt_d = DWELL_ZERO;
        end
        default: begin
          state_d     = ST_IDLE;
          out_d       = OUT_INACTIVE;
          dwell_cnt_d = DWELL_ZERO;
        end
      endcase
    end else begin
      state_d     = ST_DIRECT;
      dwell_cnt_d = DWELL_ZERO;
      if (a_valid_i) begin
        idx_d = a_i;
        out_d = decode_out(a_i);
      end else if (state_q == ST_DIRECT) begin
        // Hold the last decoded address.
        out_d = out_q;
      end else begin
        // Coming from IDLE or SCAN without a valid address: nothing selected.
        out_d = OUT_INACTIVE;
      end
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      out_q       <= OUT_INACTIVE;
      idx_q       <= ADDR_ZERO;
      wrap_q      <= 1'b0;
      dwell_cnt_q <= DWELL_ZERO;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n_to_2n.sv
module tb_decoder_scan_n_to_2n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  a;
  logic        a_valid;
  logic [7:0]  dwell;
  logic [3:0]  last;
  logic [15:0] out;
  logic [3:0]  idx;
  logic        wrap;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [15:0] POL = 16'hFFFF;
`else
  localparam logic [15:0] POL = 16'h0000;
`endif

  decoder_scan_n_to_2n #(.ADDR_W(4), .DWELL_W(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .mode_i    (mode),
    .a_i       (a),
    .a_valid_i (a_valid),
    .dwell_i   (dwell),
    .last_i    (last),
    .out_o     (out),
    .idx_o     (idx),
    .wrap_o    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check out (given as active-high one-hot), idx and wrap together.
  task automatic chk3(input string tag, input logic [15:0] onehot, input logic [3:0] ei, input logic ew);
    chk({tag, ".out"}, {16'h0000, out}, {16'h0000, onehot ^ POL});
    chk({tag, ".idx"}, {28'h0, idx}, {28'h0, ei});
    chk({tag, ".wrap"}, {31'h0, wrap}, {31'h0, ew});
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_last1 [7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; a = 4'd0; a_valid = 1'b0;
    dwell = 8'd0; last = 4'd15;
    step();
    chk3("reset", 16'h0000, 4'd0, 1'b0);
    rst = 1'b0;
    step();
    chk3("idle_en0", 16'h0000, 4'd0, 1'b0);

    // Direct decode.
    en = 1'b1; mode = 1'b0; a_valid = 1'b1; a = 4'd0;
    step(); chk3("dir_a0", 16'h0001, 4'd0, 1'b0);
    a = 4'd7;
    step(); chk3("dir_a7", 16'h0080, 4'd7, 1'b0);
    a = 4'd15;
    step(); chk3("dir_a15", 16'h8000, 4'd15, 1'b0);
    a_valid = 1'b0; a = 4'd3;
    step(); chk3("dir_hold1", 16'h8000, 4'd15, 1'b0);
    step(); chk3("dir_hold2", 16'h8000, 4'd15, 1'b0);

    // Scan, dwell=0, last=15: full walk then wrap.
    mode = 1'b1;
    step(); chk3("scan0_entry", 16'h0001, 4'd0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk3($sformatf("scan0_walk%0d", i), 16'h0001 << i, i[3:0], 1'b0);
    end
    step(); chk3("scan0_wrap", 16'h0001, 4'd0, 1'b1);
    step(); chk3("scan0_after", 16'h0002, 4'd1, 1'b0);
    step(); step(); step(); step();
    chk3("scan0_idx5", 16'h0020, 4'd5, 1'b0);

    // Asynchronous reset mid-scan, no clock edge needed.
    #2 rst = 1'b1;
    #1 chk3("async_rst", 16'h0000, 4'd0, 1'b0);
    en = 1'b0; mode = 1'b0;
    step();
    rst = 1'b0;
    step(); chk3("rst_rel1", 16'h0000, 4'd0, 1'b0);
    step(); chk3("rst_rel2", 16'h0000, 4'd0, 1'b0);

    // Scan, dwell=2, last=3: 3 cycles per index, wrap every 12.
    en = 1'b1; mode = 1'b1; dwell = 8'd2; last = 4'd3;
    for (int c = 0; c < 22; c++) begin
      step();
      chk3($sformatf("scan2_c%0d", c), 16'h0001 << ((c / 3) % 4), 4'((c / 3) % 4),
           (c % 12 == 0) && (c > 0));
    end
    // Now idx=3, first cycle of its dwell. Lower last to 1.
    last = 4'd1;
    step(); chk3("lower_c22", 16'h0008, 4'd3, 1'b0);
    step(); chk3("lower_c23", 16'h0008, 4'd3, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step();
      chk3($sformatf("last1_c%0d", c), 16'h0001 << exp_last1[c], 4'(exp_last1[c]),
           (c == 0) || (c == 6));
    end

    // dwell=0, last=0: stays on bit 0 with wrap every cycle.
    dwell = 8'd0; last = 4'd0;
    step(); chk3("l0d0_a", 16'h0001, 4'd0, 1'b1);
    step(); chk3("l0d0_b", 16'h0001, 4'd0, 1'b1);
    step(); chk3("l0d0_c", 16'h0001, 4'd0, 1'b1);

    // Mode/enable switching.
    last = 4'd15;
    for (int i = 1; i <= 6; i++) step();
    chk3("sw_idx6", 16'h0040, 4'd6, 1'b0);
    mode = 1'b0; a_valid = 1'b1; a = 4'd9;
    step(); chk3("sw_direct9", 16'h0200, 4'd9, 1'b0);
    a_valid = 1'b0; en = 1'b0;
    step(); chk3("sw_disable", 16'h0000, 4'd9, 1'b0);
    en = 1'b1; mode = 1'b1;
    step(); chk3("sw_rescan", 16'h0001, 4'd0, 1'b0);
    step(); chk3("sw_rescan1", 16'h0002, 4'd1, 1'b0);
    mode = 1'b0; a_valid = 1'b0;
    step(); chk3("sw_novalid", 16'h0000, 4'd1, 1'b0);
    a_valid = 1'b1; a = 4'd4;
    step(); chk3("sw_dir4", 16'h0010, 4'd4, 1'b0);
    en = 1'b0; a = 4'd2;
    step(); chk3("en_priority", 16'h0000, 4'd4, 1'b0);
    // Scan request with a_valid high in the same cycle: mode wins.
    en = 1'b1; mode = 1'b1; a = 4'd12;
    step(); chk3("mode_priority", 16'h0001, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
